// File: rtl/alu_md_if.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : alu_md_if
// Description : Request/response bundle for the alu_md execute unit.
//               Request side: in_valid/in_ready, m_en, func, alt, din1, din2.
//               Response side: out_valid/out_ready, dout, illegal.
//               master = requester/consumer, slave = execute unit.
// Revision    : 1.0 - initial release
// ============================================================================
interface alu_md_if #(
    parameter int XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic            m_en;
    logic [2:0]      func;
    logic            alt;
    logic [XLEN-1:0] din1;
    logic [XLEN-1:0] din2;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] dout;
    logic            illegal;

    modport master (
        output in_valid, m_en, func, alt, din1, din2, out_ready,
        input  in_ready, out_valid, dout, illegal
    );

    modport slave (
        input  in_valid, m_en, func, alt, din1, din2, out_ready,
        output in_ready, out_valid, dout, illegal
    );
endinterface
`default_nettype wire

// File: rtl/alu_md.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : alu_md
// Description : Integer execute unit. Single-cycle base ops (add/sub, shifts,
//               signed/unsigned compare, logic) plus an iterative
//               multiply/divide engine (one bit per cycle, XLEN iterations).
//               Valid/ready handshake on request and response sides.
// Ports       : clk, rst (synchronous, active-high)
//               bus (alu_md_if.slave): in_valid/in_ready, m_en, func, alt,
//               din1, din2, out_valid/out_ready, dout, illegal
// Build macro : ALU_MD_DIV_EN - when defined the divider datapath is built;
//               otherwise DIV/DIVU/REM/REMU complete in one cycle with
//               dout=0 and illegal=1.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_md #(
    parameter int XLEN = 32,
    parameter int SHW  = $clog2(XLEN)
) (
    input  logic    clk,
    input  logic    rst,
    alu_md_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [SHW:0] c_last_iter = (SHW+1)'(XLEN - 1);

    state_t            r_state;
    state_t            w_state_next;

    logic              w_in_ready;
    logic              w_accept;
    logic              w_div_illegal;
    logic              w_start_calc;
    logic              w_load_now;
    logic              w_finish;

    logic [SHW-1:0]    w_shamt;
    logic [XLEN-1:0]   w_base_res;

    logic              w_sgn1_op;
    logic              w_sgn2_op;
    logic              w_s1;
    logic              w_s2;
    logic [XLEN-1:0]   w_mag1;
    logic [XLEN-1:0]   w_mag2;

    // r_acc: multiply = {partial product high, multiplier being shifted out}
    //        divide   = {partial remainder, dividend/quotient bits}
    logic [2*XLEN-1:0] r_acc;
    logic [2*XLEN-1:0] w_acc_step;
    logic [2*XLEN-1:0] w_mul_step;
    logic [2*XLEN-1:0] w_prod;
    logic [XLEN:0]     w_mul_sum;

    logic [XLEN-1:0]   r_opb;
    logic [XLEN-1:0]   r_dout;
    logic [XLEN-1:0]   w_m_res;
    logic [2:0]        r_func;
    logic              r_neg;
    logic              r_illegal;
    logic [SHW:0]      r_cnt;

`ifdef ALU_MD_DIV_EN
    logic              r_neg_r;
    logic              r_dz;
    logic [XLEN:0]     w_div_shift;
    logic [XLEN:0]     w_div_diff;
    logic [2*XLEN-1:0] w_div_step;
    logic [XLEN-1:0]   w_quo;
    logic [XLEN-1:0]   w_rem;
`endif

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = (r_state == S_DONE);
    assign bus.dout      = r_dout;
    assign bus.illegal   = r_illegal;

    // ------------------------------------------------------------------
    // Single-cycle base ALU, evaluated straight from the request inputs
    // ------------------------------------------------------------------
    always_comb begin
        w_shamt    = bus.din2[SHW-1:0];
        w_base_res = '0;
        case (bus.func)
            3'b000: w_base_res = bus.alt ? (bus.din1 - bus.din2) : (bus.din1 + bus.din2);
            3'b001: w_base_res = bus.din1 << w_shamt;
            3'b010: w_base_res = {{(XLEN-1){1'b0}}, ($signed(bus.din1) < $signed(bus.din2))};
            3'b011: w_base_res = {{(XLEN-1){1'b0}}, (bus.din1 < bus.din2)};
            3'b100: w_base_res = bus.din1 ^ bus.din2;
            3'b101: w_base_res = bus.alt ? XLEN'($signed(bus.din1) >>> w_shamt)
                                         : (bus.din1 >> w_shamt);
            3'b110: w_base_res = bus.din1 | bus.din2;
            3'b111: w_base_res = bus.din1 & bus.din2;
        endcase
    end

    // ------------------------------------------------------------------
    // Operand preparation for M ops: signedness per func, magnitudes
    // ------------------------------------------------------------------
    always_comb begin
        w_sgn1_op = (bus.func == 3'b001) || (bus.func == 3'b010) ||
                    (bus.func == 3'b100) || (bus.func == 3'b110);
        w_sgn2_op = (bus.func == 3'b001) || (bus.func == 3'b100) ||
                    (bus.func == 3'b110);
        w_s1      = w_sgn1_op && bus.din1[XLEN-1];
        w_s2      = w_sgn2_op && bus.din2[XLEN-1];
        // Negating the most-negative value yields itself, which read as
        // unsigned is exactly its magnitude.
        w_mag1    = w_s1 ? -bus.din1 : bus.din1;
        w_mag2    = w_s2 ? -bus.din2 : bus.din2;
    end

    // ------------------------------------------------------------------
    // One iteration of the multiply / divide engine
    // ------------------------------------------------------------------
    always_comb begin
        w_mul_sum  = {1'b0, r_acc[2*XLEN-1:XLEN]} + {1'b0, r_opb};
        w_mul_step = r_acc[0] ? {w_mul_sum, r_acc[XLEN-1:1]}
                              : {1'b0, r_acc[2*XLEN-1:1]};
`ifdef ALU_MD_DIV_EN
        // Restoring step: shift next dividend bit into the remainder and
        // keep the subtraction only if it did not borrow.
        w_div_shift = {r_acc[2*XLEN-1:XLEN], r_acc[XLEN-1]};
        w_div_diff  = w_div_shift - {1'b0, r_opb};
        w_div_step  = w_div_diff[XLEN] ? {w_div_shift[XLEN-1:0], r_acc[XLEN-2:0], 1'b0}
                                       : {w_div_diff[XLEN-1:0],  r_acc[XLEN-2:0], 1'b1};
        w_acc_step  = r_func[2] ? w_div_step : w_mul_step;
`else
        w_acc_step  = w_mul_step;
`endif
    end

    // ------------------------------------------------------------------
    // Final sign fix-up and result select, applied on the last iteration
    // ------------------------------------------------------------------
    always_comb begin
        w_prod  = r_neg ? -w_acc_step : w_acc_step;
        w_m_res = '0;
`ifdef ALU_MD_DIV_EN
        w_quo   = w_acc_step[XLEN-1:0];
        w_rem   = w_acc_step[2*XLEN-1:XLEN];
`endif
        case (r_func)
            3'b000:                 w_m_res = w_acc_step[XLEN-1:0];
            3'b001, 3'b010, 3'b011: w_m_res = w_prod[2*XLEN-1:XLEN];
`ifdef ALU_MD_DIV_EN
            // Divide by zero forces an all-ones quotient; the remainder
            // already equals din1 because every trial subtract succeeds.
            3'b100, 3'b101:         w_m_res = r_dz ? '1 : (r_neg ? -w_quo : w_quo);
            3'b110, 3'b111:         w_m_res = r_neg_r ? -w_rem : w_rem;
`endif
            default:                w_m_res = '0;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: next state and handshake decode
    // ------------------------------------------------------------------
    always_comb begin
`ifdef ALU_MD_DIV_EN
        w_div_illegal = 1'b0;
`else
        w_div_illegal = bus.m_en && bus.func[2];
`endif
        w_in_ready   = !rst && ((r_state == S_IDLE) ||
                                ((r_state == S_DONE) && bus.out_ready));
        w_accept     = bus.in_valid && w_in_ready;
        w_start_calc = w_accept && bus.m_en && !w_div_illegal;
        w_load_now   = w_accept && !w_start_calc;
        w_finish     = (r_state == S_CALC) && (r_cnt == c_last_iter);
        w_state_next = r_state;

        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_next = w_start_calc ? S_CALC : S_DONE;
                end
            end
            S_CALC: begin
                if (w_finish) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                if (w_accept) begin
                    w_state_next = w_start_calc ? S_CALC : S_DONE;
                end else if (bus.out_ready) begin
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc     <= '0;
            r_opb     <= '0;
            r_func    <= '0;
            r_neg     <= 1'b0;
            r_cnt     <= '0;
            r_dout    <= '0;
            r_illegal <= 1'b0;
`ifdef ALU_MD_DIV_EN
            r_neg_r   <= 1'b0;
            r_dz      <= 1'b0;
`endif
        end else begin
            if (w_start_calc) begin
                r_acc  <= {{XLEN{1'b0}}, w_mag1};
                r_opb  <= w_mag2;
                r_func <= bus.func;
                r_neg  <= w_s1 ^ w_s2;
                r_cnt  <= '0;
`ifdef ALU_MD_DIV_EN
                r_neg_r <= w_s1;
                r_dz    <= (bus.din2 == '0);
`endif
            end else if (r_state == S_CALC) begin
                r_acc <= w_acc_step;
                r_cnt <= w_finish ? '0 : r_cnt + 1'b1;
            end

            if (w_load_now) begin
                r_dout    <= w_div_illegal ? '0 : w_base_res;
                r_illegal <= w_div_illegal;
            end else if (w_finish) begin
                r_dout    <= w_m_res;
                r_illegal <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: doc/alu_md.md
# alu_md

Parametrised integer execute unit: the next-generation ALU with the full RV-style base op set (signed/unsigned compare, arithmetic shift) plus an iterative multiply/divide engine for the M extension. It sits in the execute stage between operand select and writeback, and uses valid/ready handshakes on both sides so that multi-cycle M ops can stall the pipeline. Base ops complete in one cycle. Multiply and divide take XLEN iteration cycles.

## Interface
- XLEN, 32, operand/result width (≥8, power of two)
- SHW, $clog2(XLEN), shift-amount width (derived; do not override)

- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous reset, active-high
- in_valid  in  1  request present
- in_ready  out  1  unit can accept request this cycle
- m_en  in  1  0 = base op, 1 = M-extension op
- func  in  3  op select
- alt  in  1  base op only: SUB for func 000, SRA for func 101
- din1  in  XLEN  operand 1 (rs1)
- din2  in  XLEN  operand 2 (rs2/imm)
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- dout  out  XLEN  result
- illegal  out  1  op not supported in this build; qualified by out_valid

## Operation
- Base ops (m_en=0):
  - 000 ADD/SUB(alt)
  - 001 SLL
  - 010 SLT (signed)
  - 011 SLTU
  - 100 XOR
  - 101 SRL/SRA(alt)
  - 110 OR
  - 111 AND
  - Shift amount is din2[SHW-1:0].
  - Compare result is zero-extended to 0/1.
- M ops (m_en=1):
  - 000 MUL (low half)
  - 001 MULH (s×s)
  - 010 MULHSU (din1 signed, din2 unsigned)
  - 011 MULHU
  - 100 DIV
  - 101 DIVU
  - 110 REM
  - 111 REMU
- Multiply is a shift-add iteration over operand magnitudes into a 2·XLEN accumulator. The sign is applied by two's-complement negation of the full product in the final step.
- Divide is restoring, one quotient bit per cycle, on magnitudes. Quotient sign = sign1 XOR sign2. Remainder sign = sign of din1.
- Divide by zero: quotient = all ones; remainder = din1.
- Signed overflow (DIV/REM with din1 = most-negative, din2 = −1): quotient = din1; remainder = 0.
- Operands and control are captured at acceptance. Later changes on the inputs have no effect.
- States:
  - IDLE→DONE: base op accepted.
  - IDLE→CALC: M op accepted.
  - CALC→DONE: after XLEN iterations (iteration counter SHW+1 bits, 0..XLEN−1).
  - DONE→IDLE: out_ready=1 and no new accept.
  - DONE→DONE/CALC: out_ready=1 and in_valid=1 in the same cycle (back-to-back).
- in_ready = !rst && (state==IDLE || (state==DONE && out_ready)).
- Accept = in_valid && in_ready.

## Timing
- Reset values:
  - state IDLE
  - out_valid 0
  - dout 0
  - illegal 0
  - counter 0
  - accumulators 0
  - in_ready 0 while rst=1; 1 in the first cycle after release
- Base op: out_valid rises one edge after accept. This gives back-to-back throughput of 1/cycle with out_ready held high.
- M op: out_valid rises exactly XLEN+1 edges after accept (33 at XLEN=32). in_ready is low throughout CALC.
- dout and illegal are registered. They are stable while out_valid=1 and out_ready=0.
- rst during CALC or DONE aborts the op:
  - out_valid is 0 after that edge.
  - No partial result is ever presented.
- in_valid during CALC is ignored and not accepted. The requester must hold it.

## Configuration
- ALU_MD_DIV_EN defined:
  - Divider datapath built.
  - DIV/DIVU/REM/REMU behave as above.
  - illegal is always 0.
- ALU_MD_DIV_EN undefined:
  - No divider logic.
  - m_en=1 with func[2]=1 goes IDLE→DONE in one cycle with dout=0 and illegal=1.
  - Multiply ops are unaffected.

## Test plan
- SRA/SRL: din1=0x80000000, din2=0x24, alt=1 → dout=0xF8000000; alt=0 → 0x08000000; each out_valid one edge after accept, 1 result/cycle with out_ready=1.
- SLT vs SLTU: din1=0xFFFFFFFF, din2=1 → SLT=1, SLTU=0; SUB 0−1 → 0xFFFFFFFF.
- Multiply: din1=din2=0x80000000 → MUL=0, MULH=0x40000000, MULHU=0x40000000, MULHSU=0xC0000000; out_valid exactly 33 edges after accept, in_ready low throughout.
- Divide corners (macro defined): DIV 7/0 → 0xFFFFFFFF; REM 7/0 → 7; DIV 0x80000000/0xFFFFFFFF → 0x80000000; REM → 0; DIV −7/2 → −3 (0xFFFFFFFD); REM → −1. Macro undefined: DIV → dout=0, illegal=1 after one edge.
- Backpressure: out_ready=0 for 5 cycles after out_valid → dout/out_valid stable, in_ready=0; then out_ready=1 with in_valid=1 in the same cycle → new op accepted that edge.
- Reset mid-multiply: rst pulsed at CALC iteration 10 → out_valid=0 and state IDLE next edge; the following ADD 2+3 returns 5 with no stale result.
